// File: rtl/inst_decode_buf_pkg.sv
// Shared constants and types for the fetch/decode skid buffer and the
// immediate generator: immediate-select codes, RV32I opcodes, bubble encoding.
package inst_decode_buf_pkg;

    localparam int unsigned SEL_W  = 3;
    localparam int unsigned OPC_W  = 7;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned INST_W = 32;

    // Immediate-select codes consumed by the immediate generator
    localparam logic [SEL_W-1:0] IMM_X = 3'd0;
    localparam logic [SEL_W-1:0] IMM_I = 3'd1;
    localparam logic [SEL_W-1:0] IMM_S = 3'd2;
    localparam logic [SEL_W-1:0] IMM_U = 3'd3;
    localparam logic [SEL_W-1:0] IMM_J = 3'd4;
    localparam logic [SEL_W-1:0] IMM_B = 3'd5;
    localparam logic [SEL_W-1:0] IMM_Z = 3'd6;

    // RV32I + Zicsr major opcodes (inst[6:0])
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_FENCE  = 7'b0001111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

    // addi x0,x0,0
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    // Pre-decode result stored alongside each buffered instruction
    typedef struct packed {
        logic [SEL_W-1:0] sel;
        logic             illegal;
    } dec_t;

endpackage

// File: rtl/imm_sel_decode.sv
// Combinational opcode/funct3 -> {immediate select, illegal} mapper.
// Ports:
//   opcode     inst[6:0]
//   funct3     inst[14:12]
//   dec_c      {sel, illegal}, combinational
module imm_sel_decode
    import inst_decode_buf_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    input  logic [F3_W-1:0]  funct3,
    output dec_t             dec_c
);

    // Every legal opcode ends in 2'b11, so compressed/invalid low bits fall
    // through to the default arm and are flagged illegal there.
    always_comb begin
        dec_c.sel     = IMM_X;
        dec_c.illegal = 1'b0;
        unique case (opcode)
            OPC_LUI, OPC_AUIPC:             dec_c.sel = IMM_U;
            OPC_JAL:                        dec_c.sel = IMM_J;
            OPC_JALR, OPC_LOAD, OPC_OPIMM:  dec_c.sel = IMM_I;
            OPC_STORE:                      dec_c.sel = IMM_S;
            OPC_BRANCH:                     dec_c.sel = IMM_B;
            OPC_OP, OPC_FENCE:              dec_c.sel = IMM_X;
            // CSR immediate forms (funct3[2]=1) carry a zimm in rs1
            OPC_SYSTEM:                     dec_c.sel = funct3[2] ? IMM_Z : IMM_X;
            default: begin
                dec_c.sel     = IMM_X;
                dec_c.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/inst_decode_buf.sv
// Two-entry skid buffer between fetch and decode/immediate generation.
// Registers inst/pc plus the pre-decoded immediate select and illegal flag;
// io_in_ready is registered so decode's ready never reaches fetch combinationally.
// Optional feature macro: DECODE_BUBBLE_NOP_EN (drive a clean NOP bubble on
// io_out_* while no valid entry is presented).
// Ports:
//   clock, reset            clock, synchronous active-high reset
//   io_in_valid/ready       fetch handshake
//   io_in_inst, io_in_pc    fetched instruction and its PC
//   io_flush                redirect: drop everything buffered and the input
//   io_out_valid/ready      decode handshake
//   io_out_inst, io_out_pc  presented instruction and PC
//   io_out_sel              immediate select (IMM_* codes)
//   io_out_illegal          opcode outside RV32I+Zicsr
module inst_decode_buf
    import inst_decode_buf_pkg::*;
#(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(inst_decode_buf_pkg::NOP_INST)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [XLEN-1:0]   io_in_inst,
    input  logic [XLEN-1:0]   io_in_pc,
    input  logic              io_flush,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [XLEN-1:0]   io_out_inst,
    output logic [XLEN-1:0]   io_out_pc,
    output logic [SEL_W-1:0]  io_out_sel,
    output logic              io_out_illegal
);

    dec_t            in_dec_c;
    logic            in_xfer_c;
    logic            out_xfer_c;
    logic            main_free_c;

    logic            main_valid_q, main_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            in_ready_q;
    logic            main_ld_skid_c, main_ld_in_c, skid_ld_in_c;

    logic [XLEN-1:0] main_inst_q, main_pc_q;
    dec_t            main_dec_q;
    logic [XLEN-1:0] skid_inst_q, skid_pc_q;
    dec_t            skid_dec_q;

    // Pre-decode on the input path so the result is stored with the entry
    imm_sel_decode u_imm_sel_decode (
        .opcode (io_in_inst[6:0]),
        .funct3 (io_in_inst[14:12]),
        .dec_c  (in_dec_c)
    );

    assign in_xfer_c   = io_in_valid & in_ready_q;
    assign out_xfer_c  = main_valid_q & io_out_ready;
    assign main_free_c = ~main_valid_q | out_xfer_c;

    // Next-state: main refills from skid first to keep FIFO order
    always_comb begin
        main_valid_d   = main_valid_q;
        skid_valid_d   = skid_valid_q;
        main_ld_skid_c = 1'b0;
        main_ld_in_c   = 1'b0;
        skid_ld_in_c   = 1'b0;
        if (io_flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_free_c) begin
            if (skid_valid_q) begin
                main_ld_skid_c = 1'b1;
                main_valid_d   = 1'b1;
                skid_ld_in_c   = in_xfer_c;
                skid_valid_d   = in_xfer_c;
            end else if (in_xfer_c) begin
                main_ld_in_c = 1'b1;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_xfer_c) begin
            skid_ld_in_c = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    // Control registers; ready is a flop of the next skid state
    always_ff @(posedge clock) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= ~skid_valid_d;
        end
    end

    // Payload registers
    always_ff @(posedge clock) begin
        if (reset) begin
            main_inst_q <= NOP_INST;
            main_pc_q   <= '0;
            main_dec_q  <= '0;
            skid_inst_q <= NOP_INST;
            skid_pc_q   <= '0;
            skid_dec_q  <= '0;
        end else begin
            if (main_ld_skid_c) begin
                main_inst_q <= skid_inst_q;
                main_pc_q   <= skid_pc_q;
                main_dec_q  <= skid_dec_q;
            end else if (main_ld_in_c) begin
                main_inst_q <= io_in_inst;
                main_pc_q   <= io_in_pc;
                main_dec_q  <= in_dec_c;
            end
            if (skid_ld_in_c) begin
                skid_inst_q <= io_in_inst;
                skid_pc_q   <= io_in_pc;
                skid_dec_q  <= in_dec_c;
            end
        end
    end

    assign io_in_ready  = in_ready_q;
    assign io_out_valid = main_valid_q;

`ifdef DECODE_BUBBLE_NOP_EN
    // Downstream sees a harmless NOP whenever nothing is presented
    assign io_out_inst    = main_valid_q ? main_inst_q    : NOP_INST;
    assign io_out_pc      = main_valid_q ? main_pc_q      : '0;
    assign io_out_sel     = main_valid_q ? main_dec_q.sel : IMM_I;
    assign io_out_illegal = main_valid_q & main_dec_q.illegal;
`else
    assign io_out_inst    = main_inst_q;
    assign io_out_pc      = main_pc_q;
    assign io_out_sel     = main_dec_q.sel;
    assign io_out_illegal = main_dec_q.illegal;
`endif

endmodule

// File: tb/tb_inst_decode_buf.sv
// Scoreboard bench for inst_decode_buf: reference model is a depth-2 FIFO of
// expected {inst, pc, sel, illegal} entries; ready/valid derive from its size.
module tb_inst_decode_buf;

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  sel;
        logic        illegal;
    } exp_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              io_in_valid;
    logic              io_in_ready;
    logic [XLEN-1:0]   io_in_inst;
    logic [XLEN-1:0]   io_in_pc;
    logic              io_flush;
    logic              io_out_valid;
    logic              io_out_ready;
    logic [XLEN-1:0]   io_out_inst;
    logic [XLEN-1:0]   io_out_pc;
    logic [2:0]        io_out_sel;
    logic              io_out_illegal;

    exp_t scb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    bit   model_ready = 1'b1;
    bit   done = 1'b0;

    always #5 clock = ~clock;

    inst_decode_buf dut (
        .clock          (clock),
        .reset          (reset),
        .io_in_valid    (io_in_valid),
        .io_in_ready    (io_in_ready),
        .io_in_inst     (io_in_inst),
        .io_in_pc       (io_in_pc),
        .io_flush       (io_flush),
        .io_out_valid   (io_out_valid),
        .io_out_ready   (io_out_ready),
        .io_out_inst    (io_out_inst),
        .io_out_pc      (io_out_pc),
        .io_out_sel     (io_out_sel),
        .io_out_illegal (io_out_illegal)
    );

    // Expected pre-decode straight from the opcode table
    function automatic exp_t ref_entry(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        logic [6:0] op;
        op        = inst[6:0];
        e.inst    = inst;
        e.pc      = pc;
        e.sel     = 3'd0;
        e.illegal = 1'b0;
        case (op)
            7'b0110111, 7'b0010111:            e.sel = 3'd3;
            7'b1101111:                        e.sel = 3'd4;
            7'b1100111, 7'b0000011, 7'b0010011: e.sel = 3'd1;
            7'b0100011:                        e.sel = 3'd2;
            7'b1100011:                        e.sel = 3'd5;
            7'b0110011, 7'b0001111:            e.sel = 3'd0;
            7'b1110011:                        e.sel = inst[14] ? 3'd6 : 3'd0;
            default:                           e.illegal = 1'b1;
        endcase
        if (inst[1:0] != 2'b11) e.illegal = 1'b1;
        return e;
    endfunction

    // Output monitor: checks handshake signals and pops on each output transfer
    always @(negedge clock) begin
        if (!done && !reset) begin
            n_vec++;
            if (io_in_ready !== (scb.size() < 2)) begin
                n_fail++;
                $display("FAIL in_ready: got %b want %b (t=%0t)", io_in_ready, scb.size() < 2, $time);
            end
            model_ready = (scb.size() < 2);
            n_vec++;
            if (io_out_valid !== (scb.size() > 0)) begin
                n_fail++;
                $display("FAIL out_valid: got %b want %b (t=%0t)", io_out_valid, scb.size() > 0, $time);
            end
            if (io_out_valid && io_out_ready && scb.size() > 0) begin
                exp_t e;
                exp_t got;
                e   = scb.pop_front();
                got = {io_out_inst, io_out_pc, io_out_sel, io_out_illegal};
                n_vec++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL payload: got inst=%h pc=%h sel=%0d ill=%b want inst=%h pc=%h sel=%0d ill=%b",
                             io_out_inst, io_out_pc, io_out_sel, io_out_illegal,
                             e.inst, e.pc, e.sel, e.illegal);
                end
            end
`ifdef DECODE_BUBBLE_NOP_EN
            if (!io_out_valid) begin
                n_vec++;
                if ({io_out_inst, io_out_pc, io_out_sel, io_out_illegal} !== {32'h13, 32'h0, 3'd1, 1'b0}) begin
                    n_fail++;
                    $display("FAIL bubble: got inst=%h pc=%h sel=%0d ill=%b want inst=00000013 pc=0 sel=1 ill=0",
                             io_out_inst, io_out_pc, io_out_sel, io_out_illegal);
                end
            end
`endif
        end
    end

    // Input recorder: expectation enters the scoreboard when fetch transfers
    always @(negedge clock) begin
        #1;
        if (reset || io_flush) begin
            scb.delete();
        end else if (io_in_valid && model_ready) begin
            scb.push_back(ref_entry(io_in_inst, io_in_pc));
        end
    end

    task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic rst);
        @(posedge clock);
        #1;
        io_in_valid  = v;
        io_in_inst   = inst;
        io_in_pc     = pc;
        io_out_ready = ordy;
        io_flush     = fl;
        reset        = rst;
    endtask

    logic [6:0] opc_tab [12];
    logic [31:0] stream [5];

    initial begin
        opc_tab = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                    7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011, 7'b1111111};
        stream  = '{32'h000000B7, 32'hFE000EE3, 32'h00112023, 32'h008000EF, 32'h34015073};

        reset        = 1'b1;
        io_in_valid  = 1'b0;
        io_in_inst   = 32'h0;
        io_in_pc     = 32'h0;
        io_flush     = 1'b0;
        io_out_ready = 1'b0;
        repeat (2) @(posedge clock);

        // addi through an empty buffer
        step(1'b1, 32'h00500093, 32'h100, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // back-to-back stream at full rate
        for (int i = 0; i < 5; i++)
            step(1'b1, stream[i], 32'h200 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // stall: A held, B in skid, then drain
        step(1'b1, 32'h00100113, 32'h300, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00200193, 32'h304, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // flush with buffer full and C on the input
        step(1'b1, 32'h00100113, 32'h400, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00200193, 32'h404, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00300213, 32'h408, 1'b0, 1'b1, 1'b0);
        repeat (2) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // illegal opcode and illegal low bits
        step(1'b1, 32'h0000007F, 32'h500, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h00000010, 32'h504, 1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // reset mid-stall with both entries full
        step(1'b1, 32'h00100113, 32'h600, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h00200193, 32'h604, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        repeat (2) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // randomized traffic with bursts of back-pressure, flushes, rare resets
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] inst;
            logic        ordy;
            inst = $urandom();
            if ($urandom_range(0, 15) != 0)
                inst[6:0] = opc_tab[$urandom_range(0, 11)];
            ordy = ((c / 64) % 3 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step($urandom_range(0, 3) != 0, inst, $urandom(), ordy,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 299) == 0);
        end

        // drain and confirm nothing left outstanding
        repeat (6) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        #2;
        n_vec++;
        if (scb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries outstanding want 0", scb.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_decode_buf.md
Name: inst_decode_buf

Overview:
- Two-entry skid buffer between the fetch stage and the immediate generator / decode stage.
- Registers each fetched instruction word and its PC.
- Pre-decodes the opcode into the 3-bit immediate-select code the immediate generator consumes, plus an illegal-opcode flag.
- Breaks the combinational ready path from decode back to fetch, and supports pipeline flush on branch/exception redirect.

Parameters:
- XLEN, 32, width of instruction word and PC.
- NOP_INST, 32'h00000013, canonical bubble encoding (addi x0,x0,0).

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- io_in_valid  in  1  fetch presents an instruction
- io_in_ready  out  1  buffer can accept; registered, no combinational path from io_out_ready
- io_in_inst  in  XLEN  instruction word
- io_in_pc  in  XLEN  PC of instruction
- io_flush  in  1  redirect; kill all buffered entries
- io_out_valid  out  1  io_out_* hold a live instruction
- io_out_ready  in  1  decode consumes this cycle
- io_out_inst  out  XLEN  instruction to decode / immediate generator
- io_out_pc  out  XLEN  its PC
- io_out_sel  out  3  immediate select: 0=X, 1=I, 2=S, 3=U, 4=J, 5=B, 6=Z
- io_out_illegal  out  1  opcode not in RV32I+Zicsr set

Behaviour:
- Storage: a main (output) register and a skid register. Each holds inst, pc, sel, illegal and a valid bit.
- Outputs are driven from the main register only.
- Handshakes: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- io_in_ready = !skid_valid, registered.
- Per-cycle update when no flush:
  - Main empty or output transfer: main loads from skid if skid valid, else from the input if input transfer, else main_valid <= 0.
  - Main full and stalled: an input transfer goes to the skid register.
  - Skid valid clears when main loads from it.
  - If main loads from skid and an input transfer happens in the same cycle, the input goes into skid.
- Latency: one cycle from input transfer to io_out_valid. Full throughput (1/cycle) when out_ready stays high.
- Pre-decode is computed on io_in_inst before registering, so sel and illegal are stored with the entry.
- Opcode (inst[6:0]) to sel mapping:
  - 0110111 LUI and 0010111 AUIPC -> U
  - 1101111 JAL -> J
  - 1100111 JALR, 0000011 LOAD, 0010011 OP-IMM -> I
  - 0100011 STORE -> S
  - 1100011 BRANCH -> B
  - 0110011 OP and 0001111 FENCE -> X
  - 1110011 SYSTEM -> Z if funct3[2]=1, else X
  - Any other opcode -> X with illegal=1
  - inst[1:0] != 2'b11 -> illegal=1
- Flush:
  - main_valid and skid_valid are 0 next cycle; io_in_ready is 1 next cycle.
  - An input transfer in the flush cycle is discarded. io_in_ready still reads its registered value in that cycle.
  - Flush has priority over all other events.
- Reset: both valids 0, io_in_ready 1. Data registers reset to inst=NOP_INST, pc=0, sel=0, illegal=0.
- Payload is stable while io_out_valid=1 and io_out_ready=0.
- Order is strict FIFO; no entry is lost or duplicated.

Optional Feature:
- DECODE_BUBBLE_NOP_EN defined: when main is not valid, io_out_inst=NOP_INST, io_out_sel=1 (I), io_out_illegal=0, io_out_pc=0. Downstream sees a clean bubble.
- Undefined: io_out_* hold the last loaded payload while invalid, which saves muxes.

Decomposition:
- Shared package holds:
  - immediate-select constants IMM_X=0, IMM_I=1, IMM_S=2, IMM_U=3, IMM_J=4, IMM_B=5, IMM_Z=6, shared with the immediate generator.
  - opcode constants OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE, OPC_SYSTEM.
  - NOP_INST.
- One natural sub-module: imm_sel_decode, the combinational opcode/funct3 to {sel, illegal} mapper. It is instantiated once, on the input path.

Test Plan:
- Reset, then in_valid=1 with inst=0x00500093 (addi) and out_ready=1 -> next cycle out_valid=1, out_inst=0x00500093, sel=1, illegal=0; in_ready stays 1 throughout.
- Stream 0x000000B7 (LUI), 0xFE000EE3 (BRANCH), 0x00112023 (STORE), 0x008000EF (JAL), 0x34015073 (CSRRWI) back-to-back with out_ready=1 -> sel sequence 3,5,2,4,6 on consecutive cycles, one per cycle, in order.
- out_ready=0 while sending A then B -> A held at output, B in skid, in_ready=0 the cycle after B. Raise out_ready -> A, then B, then in_ready=1.
- Buffer full (A main, B skid), assert flush with in_valid=1 carrying C -> next cycle out_valid=0, in_ready=1, C never appears.
- inst=0x0000007F (opcode 1111111) -> sel=0, illegal=1. inst=0x00000013 with bits[1:0]=00 (0x00000010) -> illegal=1.
- Reset asserted mid-stall with both entries full -> next cycle out_valid=0, in_ready=1. With DECODE_BUBBLE_NOP_EN, out_inst=0x00000013.
